// File: rtl/bin_to_bcd_seq_if.sv
// Handshake/result bundle between a binary source and the bin_to_bcd_seq converter.
// The master drives start/bin; the converter (slave) returns busy/done/bcd/overflow/blank.
interface bin_to_bcd_seq_if #(
   parameter int IN_WIDTH = 16,
   parameter int DIGITS   = 5
);
   logic                  start;
   logic [IN_WIDTH-1:0]   bin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic                  overflow;
   logic [DIGITS-1:0]     blank;

   modport master (
      output start, bin,
      input  busy, done, bcd, overflow, blank
   );

   modport slave (
      input  start, bin,
      output busy, done, bcd, overflow, blank
   );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift per cycle, result held between runs.
// Define BIN_TO_BCD_BLANK_EN to build the leading-zero blank mask; otherwise blank is tied to 0.
module bin_to_bcd_seq #(
   parameter int IN_WIDTH = 16,
   parameter int DIGITS   = 5
) (
   input  logic            clk,
   input  logic            rst,
   bin_to_bcd_seq_if.slave bus
);
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(IN_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   state_t               state_q, state_d;
   logic [IN_WIDTH-1:0]  shift_q, shift_d;
   logic [BCD_W-1:0]     scratch_q, scratch_d;
   logic                 ovf_q, ovf_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BCD_W-1:0]     bcd_q, bcd_d;
   logic                 overflow_q, overflow_d;
   logic                 done_q, done_d;
   logic [BCD_W-1:0]     adj;

   // Add-3 correction uses the pre-add value of every digit in parallel.
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5) ?
                                 scratch_q[4*gi +: 4] + 4'd3 :
                                 scratch_q[4*gi +: 4];
      end
   endgenerate

`ifdef BIN_TO_BCD_BLANK_EN
   logic [DIGITS-1:0] blank_q, blank_d, blank_calc;

   // A digit blanks when it and every digit above it are zero; units never blank.
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_blank
         if (gi == 0) begin : g_units
            assign blank_calc[gi] = 1'b0;
         end else begin : g_upper
            assign blank_calc[gi] = ~ovf_q && (scratch_q[BCD_W-1:4*gi] == '0);
         end
      end
   endgenerate

   assign bus.blank = blank_q;
`else
   assign bus.blank = '0;
`endif

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      scratch_d  = scratch_q;
      ovf_d      = ovf_q;
      cnt_d      = cnt_q;
      bcd_d      = bcd_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;
`ifdef BIN_TO_BCD_BLANK_EN
      blank_d    = blank_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               shift_d   = bus.bin;
               scratch_d = '0;
               ovf_d     = 1'b0;
               cnt_d     = CNT_W'(IN_WIDTH);
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            // The bit leaving the top digit is a lost multiple of 10^DIGITS.
            {scratch_d, shift_d} = {adj[BCD_W-2:0], shift_q, 1'b0};
            ovf_d = ovf_q | adj[BCD_W-1];
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            bcd_d      = scratch_q;
            overflow_d = ovf_q;
            done_d     = 1'b1;
`ifdef BIN_TO_BCD_BLANK_EN
            blank_d    = blank_calc;
`endif
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         scratch_q  <= '0;
         ovf_q      <= 1'b0;
         cnt_q      <= '0;
         bcd_q      <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
`ifdef BIN_TO_BCD_BLANK_EN
         blank_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         scratch_q  <= scratch_d;
         ovf_q      <= ovf_d;
         cnt_q      <= cnt_d;
         bcd_q      <= bcd_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
`ifdef BIN_TO_BCD_BLANK_EN
         blank_q    <= blank_d;
`endif
      end
   end

   assign bus.busy     = (state_q == SHIFT);
   assign bus.done     = done_q;
   assign bus.bcd      = bcd_q;
   assign bus.overflow = overflow_q;
endmodule
